state_loader: RTL
=================

STATE_LOADER -- requirements
Module: state_loader

Interface
REQ-001 Parameters: DATA_WIDTH, default 32, real/imag component width; STATE_DATA_WIDTH, default DATA_WIDTH*2, amplitude word width; STATE_ADDR_WIDTH, default 16, per-PE state RAM address width; PE_NUM_WIDTH, default 2, PE index width; GA_W = PE_NUM_WIDTH+STATE_ADDR_WIDTH, global address width.
REQ-002 Ports:
- clk  in  1  only clock; all logic on the rising edge
- rst_n  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle start pulse
- i_mode  in  1  0 = load (host to RAM), 1 = dump (RAM to host)
- i_base_addr  in  GA_W  first global address {PE, local}
- i_num_words  in  GA_W+1  transfer length in words
- i_abort  in  1  synchronous abort
- s_valid / s_ready  in / out  1 / 1  load stream handshake
- s_data  in  STATE_DATA_WIDTH  load stream amplitude
- m_valid / m_ready  out / in  1 / 1  dump stream handshake
- m_data  out  STATE_DATA_WIDTH  dump stream amplitude
- o_state_ram_off_chip_en / _we  out  1 / 1  port-A off-chip access strobes to all LSUs
- o_state_ram_off_chip_addr  out  GA_W  global address
- o_state_ram_off_chip_data  out  STATE_DATA_WIDTH  write data
- i_state_rd_data  in  STATE_DATA_WIDTH*2^PE_NUM_WIDTH  port-A read data of every PE; PE p occupies slice p
- o_busy  out  1  high outside IDLE
- o_done  out  1  one-cycle completion pulse
- o_checksum  out  STATE_DATA_WIDTH  transfer checksum

Function
REQ-003 FSM states: IDLE, LOAD, DUMP, DRAIN; IDLE samples i_start only when o_busy=0; i_start in other states is ignored.
REQ-004 i_start with i_num_words=0: stay in IDLE, pulse o_done the next cycle, no RAM access.
REQ-005 i_start with i_num_words>0: latch base, length and mode; go to LOAD (mode 0) or DUMP (mode 1); clear word index and checksum.
REQ-006 LOAD: s_ready=1 while words remain, otherwise 0; each s_valid&s_ready handshake registers en=1, we=1, addr=base+index, data=s_data for exactly the next cycle; en=0 in all other cycles.
REQ-007 Address arithmetic is modulo 2^GA_W; base+index wraps from all-ones to 0 without error.
REQ-008 After the last load handshake, the final write is presented the next cycle; o_done pulses one cycle after that; the FSM returns to IDLE.
REQ-009 DUMP: the block issues a read (en=1, we=0, addr=base+index) only when (FIFO occupancy + reads in flight − pops this cycle) < 2.
REQ-010 Read data for an issue in cycle k is selected from i_state_rd_data by the registered PE field of that address in cycle k+1, written into a 2-entry output FIFO at the end of k+1, and visible on m_valid/m_data from cycle k+2.
REQ-011 With m_ready held high, the block sustains one read issue and one m handshake per cycle.
REQ-012 m_data/m_valid hold stable while m_valid=1 and m_ready=0; the FIFO never overflows and drops no word.
REQ-013 After the last issue, move to DRAIN; o_done pulses in the cycle after the last m handshake; the FSM returns to IDLE.
REQ-014 i_abort=1 in any non-IDLE state: next cycle go to IDLE, flush the FIFO, discard in-flight reads, deassert en/we, no o_done; i_abort in IDLE has no effect.
REQ-015 s_ready=0 outside LOAD; m_valid=0 outside DUMP/DRAIN.

Reset
REQ-016 rst_n low asynchronously forces IDLE, FIFO empty, index 0, and all outputs 0, including mid-transfer; no o_done follows reset.

Configuration
REQ-017 Macro STATE_LOADER_CHECKSUM_EN defined: o_checksum is the XOR of every word written (load) or delivered on m (dump) in the current transfer; it is cleared on start and held after o_done until the next start.
REQ-018 Macro STATE_LOADER_CHECKSUM_EN undefined: o_checksum is constant 0 and no accumulator logic exists.

Verification
REQ-019 Load base=0x0FFFE, num=4, s_valid always 1: writes at 0x0FFFE, 0x0FFFF, 0x10000, 0x10001 on consecutive cycles -> the PE field moves 0 to 1 at the third write; o_done one cycle after the fourth write.
REQ-020 Load base=0x3FFFF, num=2: addresses 0x3FFFF then 0x00000 -> wrap-around per REQ-007.
REQ-021 Dump num=8 from base=0x20000, m_ready=1: first m_valid 2 cycles after the first read issue -> 8 consecutive beats with data taken from slice 2 of i_state_rd_data.
REQ-022 Dump num=8 with m_ready toggling 1,0,0,1 repeating: exactly 8 beats in address order, none duplicated or lost, read issues never exceeding the 2-entry limit.
REQ-023 Abort after 3 of 10 load words, then start again with num=0 -> no o_done for the aborted transfer; o_done one cycle after the second start; with the macro defined, o_checksum=0.
REQ-024 rst_n pulsed low mid-dump -> all outputs 0 immediately, IDLE, and a fresh dump then completes correctly.

Source files
------------

// File: rtl/state_loader.sv
// Moves state-vector amplitudes between a host stream and the per-PE state RAMs (load and dump).
// Define STATE_LOADER_CHECKSUM_EN to add an XOR checksum of the transferred words.
module state_loader #(
    parameter int DATA_WIDTH       = 32,
    parameter int STATE_DATA_WIDTH = DATA_WIDTH*2,
    parameter int STATE_ADDR_WIDTH = 16,
    parameter int PE_NUM_WIDTH     = 2,
    parameter int GA_W             = PE_NUM_WIDTH + STATE_ADDR_WIDTH
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         i_start,
    input  logic                                         i_mode,
    input  logic [GA_W-1:0]                              i_base_addr,
    input  logic [GA_W:0]                                i_num_words,
    input  logic                                         i_abort,
    input  logic                                         s_valid,
    output logic                                         s_ready,
    input  logic [STATE_DATA_WIDTH-1:0]                  s_data,
    output logic                                         m_valid,
    input  logic                                         m_ready,
    output logic [STATE_DATA_WIDTH-1:0]                  m_data,
    output logic                                         o_state_ram_off_chip_en,
    output logic                                         o_state_ram_off_chip_we,
    output logic [GA_W-1:0]                              o_state_ram_off_chip_addr,
    output logic [STATE_DATA_WIDTH-1:0]                  o_state_ram_off_chip_data,
    input  logic [STATE_DATA_WIDTH*(2**PE_NUM_WIDTH)-1:0] i_state_rd_data,
    output logic                                         o_busy,
    output logic                                         o_done,
    output logic [STATE_DATA_WIDTH-1:0]                  o_checksum
);

    typedef enum logic [1:0] {IDLE, LOAD, DUMP, DRAIN} state_t;
    state_t state, state_nxt;

    logic [GA_W-1:0]             base_q;
    logic [GA_W:0]               num_q;
    logic [GA_W:0]               idx_q;
    logic [GA_W:0]               beat_q;
    logic                        wr_en_q;
    logic [GA_W-1:0]             wr_addr_q;
    logic [STATE_DATA_WIDTH-1:0] wr_data_q;
    logic                        rd_pend_q;
    logic [PE_NUM_WIDTH-1:0]     rd_pe_q;
    logic [STATE_DATA_WIDTH-1:0] fifo_mem [2];
    logic                        fifo_wp;
    logic                        fifo_rp;
    logic [1:0]                  fifo_cnt;
    logic                        done_q;

    logic                        start_ok;
    logic                        words_left;
    logic                        s_fire;
    logic                        m_fire;
    logic                        rd_issue;
    logic                        last_beat;
    logic [GA_W-1:0]             cur_addr;
    logic [STATE_DATA_WIDTH-1:0] rd_word;

    assign start_ok = i_start && (state == IDLE);
    assign rd_word  = i_state_rd_data[rd_pe_q*STATE_DATA_WIDTH +: STATE_DATA_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        s_ready    = 1'b0;
        s_fire     = 1'b0;
        m_valid    = 1'b0;
        m_data     = '0;
        m_fire     = 1'b0;
        rd_issue   = 1'b0;
        last_beat  = 1'b0;
        words_left = (idx_q < num_q);
        cur_addr   = base_q + idx_q[GA_W-1:0];

        if (state == LOAD) s_ready = words_left;
        s_fire = s_valid && s_ready;
        if (state == DUMP || state == DRAIN) m_valid = (fifo_cnt != 2'd0);
        if (m_valid) m_data = fifo_mem[fifo_rp];
        m_fire    = m_valid && m_ready;
        last_beat = m_fire && ((beat_q + 1'b1) == num_q);
        // Reads in flight count against the FIFO so a stalled sink can never overflow it.
        if (state == DUMP && words_left)
            rd_issue = ({1'b0, fifo_cnt} + {2'b0, rd_pend_q}) < (3'd2 + {2'b0, m_fire});

        case (state)
            IDLE:    if (i_start && i_num_words != '0) state_nxt = i_mode ? DUMP : LOAD;
            LOAD:    if (!words_left) state_nxt = IDLE;
            DUMP:    if (rd_issue && ((idx_q + 1'b1) == num_q)) state_nxt = DRAIN;
            DRAIN:   if (last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (state != IDLE && i_abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q      <= '0;
            num_q       <= '0;
            idx_q       <= '0;
            beat_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_pend_q   <= 1'b0;
            rd_pe_q     <= '0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            fifo_wp     <= 1'b0;
            fifo_rp     <= 1'b0;
            fifo_cnt    <= 2'd0;
            done_q      <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_pend_q <= rd_issue && !i_abort;
            if (rd_issue) rd_pe_q <= cur_addr[GA_W-1 -: PE_NUM_WIDTH];

            if (start_ok) begin
                base_q <= i_base_addr;
                num_q  <= i_num_words;
                idx_q  <= '0;
                beat_q <= '0;
                done_q <= (i_num_words == '0);
            end
            if (s_fire && !i_abort) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= cur_addr;
                wr_data_q <= s_data;
                idx_q     <= idx_q + 1'b1;
            end
            if (rd_issue) idx_q <= idx_q + 1'b1;
            if (m_fire) beat_q <= beat_q + 1'b1;
            if (!i_abort && ((state == LOAD && !words_left) || (state == DRAIN && last_beat)))
                done_q <= 1'b1;

            // Leaving the transfer (normally or by abort) discards anything still queued.
            if (state == IDLE || i_abort) begin
                fifo_wp  <= 1'b0;
                fifo_rp  <= 1'b0;
                fifo_cnt <= 2'd0;
            end else begin
                if (rd_pend_q) begin
                    fifo_mem[fifo_wp] <= rd_word;
                    fifo_wp           <= ~fifo_wp;
                end
                if (m_fire) fifo_rp <= ~fifo_rp;
                fifo_cnt <= fifo_cnt + {1'b0, rd_pend_q} - {1'b0, m_fire};
            end
        end
    end

`ifdef STATE_LOADER_CHECKSUM_EN
    logic [STATE_DATA_WIDTH-1:0] chk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 chk_q <= '0;
        else if (start_ok)          chk_q <= '0;
        else if (s_fire && !i_abort) chk_q <= chk_q ^ s_data;
        else if (m_fire)            chk_q <= chk_q ^ m_data;
    end

    assign o_checksum = chk_q;
`else
    assign o_checksum = '0;
`endif

    assign o_busy                    = (state != IDLE);
    assign o_done                    = done_q;
    assign o_state_ram_off_chip_en   = wr_en_q | rd_issue;
    assign o_state_ram_off_chip_we   = wr_en_q;
    assign o_state_ram_off_chip_addr = wr_en_q ? wr_addr_q : (rd_issue ? cur_addr : '0);
    assign o_state_ram_off_chip_data = wr_data_q;

endmodule
